lcd_hd44780_writer: RTL and testbench
=====================================

// Module: lcd_hd44780_writer
// PURPOSE
//  Consumer end of the lcd_valid/lcd_ready/lcd_data_str_* interface driven by the AXI-lite LCD register bank.
//  Accepts one 2x16 character frame per handshake, snapshots it and writes it to an HD44780-compatible
//  character LCD (8-bit bus, write-only), then raises lcd_ready again. Runs the LCD power-up init itself.
// PARAMETERS
//  POWERUP_CYC     2000000  cycles waited after reset before first init write (40 ms @ 50 MHz)
//  SETUP_CYC       3        cycles RS/DB stable with E low before the E pulse
//  E_PULSE_CYC     25       cycles E held high per write
//  CMD_WAIT_CYC    2500     cycles E low after each write before the next (50 us)
//  CLEAR_WAIT_CYC  100000   post-write wait used instead of CMD_WAIT_CYC after 0x01 clear (2 ms)
// PORTS
//  S_AXI_ACLK         in   1   clock
//  S_AXI_ARESETN      in   1   reset, asynchronous, active-low
//  lcd_valid          in   1   frame request from register bank (may be a 1-cycle pulse)
//  lcd_ready          out  1   high only when idle and able to accept a frame
//  lcd_data_str_L_W   in   32  8 ports, L=0..1 line, W=0..3 word; 4 chars per word
//  lcd_rs             out  1   LCD register select (0 command, 1 data)
//  lcd_rw             out  1   LCD read/write, constant 0
//  lcd_e              out  1   LCD enable strobe
//  lcd_db             out  8   LCD data bus
// BEHAVIOUR
//  - Reset (async): lcd_ready=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0, FSM->PWRUP, all counters 0.
//    Reset asserted mid-write drops lcd_e immediately; full power-up/init re-runs after release.
//  - Top FSM: PWRUP -> INIT -> IDLE -> L0_ADDR -> L0_CHR -> L1_ADDR -> L1_CHR -> IDLE.
//    PWRUP: count POWERUP_CYC. INIT: commands 0x38, 0x0C, 0x01, 0x06 in that order (RS=0).
//    L0_ADDR: cmd 0x80. L0_CHR: 16 data bytes (RS=1). L1_ADDR: cmd 0xC0. L1_CHR: 16 data bytes.
//  - Byte-write sub-sequence, every byte: SETUP (E=0, SETUP_CYC) -> PULSE (E=1, E_PULSE_CYC)
//    -> HOLD (E=0, CMD_WAIT_CYC or CLEAR_WAIT_CYC). RS/DB change only on entry to SETUP, stable through HOLD.
//  - Handshake: accept = lcd_valid & lcd_ready. On accept all 256 input bits snapshot into a shadow
//    register; lcd_ready deasserts the next cycle; inputs are don't-care afterwards.
//    lcd_valid while lcd_ready=0 is ignored, not queued (software polls ready).
//  - Character order: char k (0..15) of line L = lcd_data_str_L_(k/4)[8*(k%4)+:8]; k=0 sent first.
//    Char index counter 0..15, wraps to 0 on line switch; no bytes skipped, all 32 always sent.
//  - lcd_ready rises the cycle after the HOLD of the 34th byte (and after last INIT HOLD) ends.
//  - Frame time = 32*(SETUP+E_PULSE+CMD_WAIT) + 2*(same) cycles; no display clear per frame.
//  - Counter widths sized by $clog2 of the largest parameter; no overflow possible.
// CONFIGURATION
//  LCD_4BIT_EN defined: 4-bit bus. Only lcd_db[7:4] used, lcd_db[3:0] held 0. Each byte = two full
//    SETUP/PULSE sub-sequences, high nibble first, CMD_WAIT_CYC between nibbles, normal HOLD after low.
//    INIT becomes: single nibble 0x2 write, then 0x28, 0x0C, 0x01, 0x06. Frame time doubles.
//  LCD_4BIT_EN undefined: 8-bit bus as above; nibble logic absent.
// TESTING  (params POWERUP=10, SETUP=1, E_PULSE=2, CMD_WAIT=4, CLEAR_WAIT=8; byte=7, clear=11 cyc)
//  1 Release reset -> E falls with RS=0, DB=0x38,0x0C,0x01,0x06; lcd_ready=1 at cycle 42 after release.
//  2 Frame "HELLO WORLD 1234"/"abcdefghijklmnop", 1-cycle valid -> DB 0x80, 16 chars RS=1, 0xC0,
//    16 chars in order; lcd_ready low exactly 238 cycles.
//  3 lcd_valid pulses while lcd_ready=0 -> no extra E pulses; exactly 34 writes per accepted frame.
//  4 Change all lcd_data_str_* to 0xFFFFFFFF right after accept -> LCD receives original snapshot.
//  5 Assert reset during PULSE of 10th char -> lcd_e=0 same cycle; after release full init re-runs, then ready.
//  6 LCD_4BIT_EN, send 'A' (0x41) -> nibbles 0x4 then 0x1 on lcd_db[7:4], lcd_db[3:0]=0, RS=1 both.

Source files
------------

// File: rtl/lcd_hd44780_writer_if.sv
// Frame handshake between the LCD register bank (master) and the LCD writer (slave).
// A frame moves on a clock edge where lcd_valid and lcd_ready are both high; lcd_valid while lcd_ready is low is dropped.
interface lcd_hd44780_writer_if;
    logic        lcd_valid;
    logic        lcd_ready;
    logic [31:0] lcd_data_str_0_0;
    logic [31:0] lcd_data_str_0_1;
    logic [31:0] lcd_data_str_0_2;
    logic [31:0] lcd_data_str_0_3;
    logic [31:0] lcd_data_str_1_0;
    logic [31:0] lcd_data_str_1_1;
    logic [31:0] lcd_data_str_1_2;
    logic [31:0] lcd_data_str_1_3;

    modport master (
        output lcd_valid,
        output lcd_data_str_0_0, lcd_data_str_0_1, lcd_data_str_0_2, lcd_data_str_0_3,
        output lcd_data_str_1_0, lcd_data_str_1_1, lcd_data_str_1_2, lcd_data_str_1_3,
        input  lcd_ready
    );

    modport slave (
        input  lcd_valid,
        input  lcd_data_str_0_0, lcd_data_str_0_1, lcd_data_str_0_2, lcd_data_str_0_3,
        input  lcd_data_str_1_0, lcd_data_str_1_1, lcd_data_str_1_2, lcd_data_str_1_3,
        output lcd_ready
    );
endinterface

// File: rtl/lcd_hd44780_writer.sv
// HD44780 frame writer: power-up init, then one 2x16 frame per handshake written as 34 timed bus writes.
// Define LCD_4BIT_EN for a 4-bit bus (lcd_db[7:4] only, two nibble strobes per byte).
module lcd_hd44780_writer #(
    parameter int POWERUP_CYC    = 2000000,
    parameter int SETUP_CYC      = 3,
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    lcd_hd44780_writer_if.slave  bus,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_e,
    output logic [7:0]           lcd_db,
    output logic [4:0]           o_dbg_state
);

    localparam int MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > SETUP_CYC) ? MAX_AB : SETUP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWRUP_LAST = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

`ifdef LCD_4BIT_EN
    localparam logic [3:0] INIT_LAST = 4'd4;

    // Entry 0 is the lone 0x2 nibble that switches the controller into 4-bit mode.
    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h02;
            4'd1:    return 8'h28;
            4'd2:    return 8'h0C;
            4'd3:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`else
    localparam logic [3:0] INIT_LAST = 4'd3;

    function automatic logic [7:0] init_cmd(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0C;
            4'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT, ST_IDLE, ST_L0_ADDR, ST_L0_CHR, ST_L1_ADDR, ST_L1_CHR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_PULSE, PH_HOLD
    } phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_idx;
    logic            r_clear;
    logic            r_ready;
    logic            r_e;
    logic            r_rs;
    logic [7:0]      r_db;
    logic [15:0][7:0] r_line0;
    logic [15:0][7:0] r_line1;
`ifdef LCD_4BIT_EN
    logic [7:0]      r_byte;
    logic            r_lo_nib;
`endif

    state_t          w_nxt_state;
    logic [3:0]      w_nxt_idx;
    logic [7:0]      w_nxt_byte;
    logic            w_nxt_rs;
    logic            w_nxt_idle;
    logic [CW-1:0]   w_phase_last;
    logic            w_cnt_done;
    logic            w_is_write;
    logic            w_byte_done;
    logic            w_accept;
    logic            w_load;

    // What to write next once the current byte (or power-up wait, or idle) finishes.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx + 4'd1;
        w_nxt_byte  = 8'h00;
        w_nxt_rs    = 1'b0;
        w_nxt_idle  = 1'b0;
        case (r_state)
            ST_PWRUP: begin
                w_nxt_state = ST_INIT;
                w_nxt_idx   = 4'd0;
                w_nxt_byte  = init_cmd(4'd0);
            end
            ST_INIT: begin
                if (r_idx == INIT_LAST) w_nxt_idle = 1'b1;
                else                    w_nxt_byte = init_cmd(r_idx + 4'd1);
            end
            ST_IDLE: begin
                w_nxt_state = ST_L0_ADDR;
                w_nxt_idx   = 4'd0;
                w_nxt_byte  = 8'h80;
            end
            ST_L0_ADDR: begin
                w_nxt_state = ST_L0_CHR;
                w_nxt_idx   = 4'd0;
                w_nxt_byte  = r_line0[0];
                w_nxt_rs    = 1'b1;
            end
            ST_L0_CHR: begin
                if (r_idx == 4'd15) begin
                    w_nxt_state = ST_L1_ADDR;
                    w_nxt_idx   = 4'd0;
                    w_nxt_byte  = 8'hC0;
                end else begin
                    w_nxt_byte  = r_line0[r_idx + 4'd1];
                    w_nxt_rs    = 1'b1;
                end
            end
            ST_L1_ADDR: begin
                w_nxt_state = ST_L1_CHR;
                w_nxt_idx   = 4'd0;
                w_nxt_byte  = r_line1[0];
                w_nxt_rs    = 1'b1;
            end
            ST_L1_CHR: begin
                if (r_idx == 4'd15) w_nxt_idle = 1'b1;
                else begin
                    w_nxt_byte = r_line1[r_idx + 4'd1];
                    w_nxt_rs   = 1'b1;
                end
            end
            default: w_nxt_idle = 1'b1;
        endcase
    end

    always_comb begin
        case (r_phase)
            PH_SETUP: w_phase_last = SETUP_LAST;
            PH_PULSE: w_phase_last = PULSE_LAST;
`ifdef LCD_4BIT_EN
            default:  w_phase_last = (r_clear && r_lo_nib) ? CLEAR_LAST : CMD_LAST;
`else
            default:  w_phase_last = r_clear ? CLEAR_LAST : CMD_LAST;
`endif
        endcase
    end

    assign w_cnt_done = (r_cnt == w_phase_last);
    assign w_is_write = (r_state != ST_PWRUP) && (r_state != ST_IDLE);
`ifdef LCD_4BIT_EN
    assign w_byte_done = w_is_write && (r_phase == PH_HOLD) && w_cnt_done && r_lo_nib;
`else
    assign w_byte_done = w_is_write && (r_phase == PH_HOLD) && w_cnt_done;
`endif
    assign w_accept = (r_state == ST_IDLE) && bus.lcd_valid && r_ready;
    assign w_load   = ((r_state == ST_PWRUP) && (r_cnt == PWRUP_LAST)) || w_accept ||
                      (w_byte_done && !w_nxt_idle);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state  <= ST_PWRUP;
            r_phase  <= PH_SETUP;
            r_cnt    <= '0;
            r_idx    <= 4'd0;
            r_clear  <= 1'b0;
            r_ready  <= 1'b0;
            r_e      <= 1'b0;
            r_rs     <= 1'b0;
            r_db     <= 8'h00;
            r_line0  <= '0;
            r_line1  <= '0;
`ifdef LCD_4BIT_EN
            r_byte   <= 8'h00;
            r_lo_nib <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_state <= w_nxt_state;
                r_idx   <= w_nxt_idx;
                r_rs    <= w_nxt_rs;
                r_clear <= (w_nxt_byte == 8'h01) && !w_nxt_rs;
                r_phase <= PH_SETUP;
                r_cnt   <= '0;
`ifdef LCD_4BIT_EN
                r_byte   <= w_nxt_byte;
                r_lo_nib <= (r_state == ST_PWRUP);
                r_db     <= (r_state == ST_PWRUP) ? {w_nxt_byte[3:0], 4'h0}
                                                  : {w_nxt_byte[7:4], 4'h0};
`else
                r_db    <= w_nxt_byte;
`endif
            end else if (w_byte_done) begin
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
                r_phase <= PH_SETUP;
                r_cnt   <= '0;
            end else if (r_state == ST_PWRUP) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_is_write) begin
                if (!w_cnt_done) begin
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_cnt <= '0;
                    case (r_phase)
                        PH_SETUP: begin
                            r_phase <= PH_PULSE;
                            r_e     <= 1'b1;
                        end
                        PH_PULSE: begin
                            r_phase <= PH_HOLD;
                            r_e     <= 1'b0;
                        end
                        default: begin
`ifdef LCD_4BIT_EN
                            // High nibble done: present the low nibble with the same RS.
                            r_lo_nib <= 1'b1;
                            r_db     <= {r_byte[3:0], 4'h0};
`endif
                            r_phase  <= PH_SETUP;
                        end
                    endcase
                end
            end

            if (w_accept) begin
                r_ready <= 1'b0;
                r_line0 <= {bus.lcd_data_str_0_3, bus.lcd_data_str_0_2,
                            bus.lcd_data_str_0_1, bus.lcd_data_str_0_0};
                r_line1 <= {bus.lcd_data_str_1_3, bus.lcd_data_str_1_2,
                            bus.lcd_data_str_1_1, bus.lcd_data_str_1_0};
            end
        end
    end

    assign bus.lcd_ready = r_ready;
    assign lcd_rs        = r_rs;
    assign lcd_rw        = 1'b0;
    assign lcd_e         = r_e;
    assign lcd_db        = r_db;
    assign o_dbg_state   = {r_state, r_phase};

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Bench for lcd_hd44780_writer: init sequence, table and random frames, busy-valid drops, mid-write reset.
module tb_lcd_hd44780_writer;
    localparam int P_PWR  = 10;
    localparam int P_SET  = 1;
    localparam int P_PUL  = 2;
    localparam int P_CMD  = 4;
    localparam int P_CLR  = 8;
    localparam int BUDGET = 3000;
`ifdef LCD_4BIT_EN
    localparam int INIT_CYC  = 77;
    localparam int FRAME_CYC = 476;
    localparam int RPB       = 2;
`else
    localparam int INIT_CYC  = 42;
    localparam int FRAME_CYC = 238;
    localparam int RPB       = 1;
`endif

    typedef struct packed {
        logic [255:0] w;
        logic [7:0]   c0;
        logic [7:0]   c31;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;
    logic [4:0] dbg_state;

    lcd_hd44780_writer_if bus();

    lcd_hd44780_writer #(
        .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SET), .E_PULSE_CYC(P_PUL),
        .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLR)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(bus),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_q[$];
    int         pw_q[$];
    bit         stab_q[$];
    int         rise_cnt = 0;
    logic       m_prev_e = 1'b0;
    int         m_hi = 0;
    logic [8:0] m_rise_val = '0;
    vec_t       vecs [5];

    // Bus monitor: one record per E strobe (value at the falling edge, width, stability).
    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_e = 1'b0;
            m_hi     = 0;
        end else begin
            if (lcd_e && !m_prev_e) begin
                rise_cnt++;
                m_rise_val = {lcd_rs, lcd_db};
                m_hi = 0;
            end
            if (lcd_e) m_hi++;
            if (!lcd_e && m_prev_e) begin
                mon_q.push_back({lcd_rs, lcd_db});
                pw_q.push_back(m_hi);
                stab_q.push_back(({lcd_rs, lcd_db} === m_rise_val) && (lcd_rw === 1'b0));
            end
            m_prev_e = lcd_e;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the strobe sequence the LCD should see for a byte.
    function automatic void push_byte(input logic rs, input logic [7:0] b);
`ifdef LCD_4BIT_EN
        exp_q.push_back({rs, b[7:4], 4'h0});
        exp_q.push_back({rs, b[3:0], 4'h0});
`else
        exp_q.push_back({rs, b});
`endif
    endfunction

    function automatic void model_init();
        logic [7:0] cmds [4];
`ifdef LCD_4BIT_EN
        cmds = '{8'h28, 8'h0C, 8'h01, 8'h06};
        exp_q.push_back({1'b0, 8'h20});
`else
        cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
`endif
        for (int i = 0; i < 4; i++) push_byte(1'b0, cmds[i]);
    endfunction

    function automatic logic [7:0] frame_char(input logic [255:0] w, input int line, input int k);
        logic [255:0] t;
        t = w >> (32 * (4 * line + k / 4) + 8 * (k % 4));
        return t[7:0];
    endfunction

    function automatic void model_frame(input logic [255:0] w);
        push_byte(1'b0, 8'h80);
        for (int k = 0; k < 16; k++) push_byte(1'b1, frame_char(w, 0, k));
        push_byte(1'b0, 8'hC0);
        for (int k = 0; k < 16; k++) push_byte(1'b1, frame_char(w, 1, k));
    endfunction

    function automatic logic [7:0] cap_byte(input int i);
        logic [8:0] a, b;
`ifdef LCD_4BIT_EN
        if (mon_q.size() <= 2 * i + 1) return 8'hxx;
        a = mon_q[2 * i];
        b = mon_q[2 * i + 1];
        return {a[7:4], b[7:4]};
`else
        if (mon_q.size() <= i) return 8'hxx;
        a = mon_q[i];
        b = a;
        return b[7:0];
`endif
    endfunction

    task automatic clear_queues();
        exp_q.delete();
        mon_q.delete();
        pw_q.delete();
        stab_q.delete();
    endtask

    task automatic compare_stream(input string name);
        logic [8:0] e, m;
        chk({name, " strobe count"}, mon_q.size(), exp_q.size());
        while (exp_q.size() > 0 && mon_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mon_q.pop_front();
            chk({name, " rs/db"}, {23'd0, m}, {23'd0, e});
            chk({name, " e width"}, pw_q.pop_front(), P_PUL);
            chk({name, " rs/db stable"}, {31'd0, stab_q.pop_front()}, 1);
        end
        clear_queues();
    endtask

    task automatic set_words(input logic [255:0] w);
        bus.lcd_data_str_0_0 = w[31:0];
        bus.lcd_data_str_0_1 = w[63:32];
        bus.lcd_data_str_0_2 = w[95:64];
        bus.lcd_data_str_0_3 = w[127:96];
        bus.lcd_data_str_1_0 = w[159:128];
        bus.lcd_data_str_1_1 = w[191:160];
        bus.lcd_data_str_1_2 = w[223:192];
        bus.lcd_data_str_1_3 = w[255:224];
    endtask

    task automatic wait_init(input string name);
        int cnt = 0;
        while (bus.lcd_ready !== 1'b1 && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        chk({name, " ready latency"}, cnt, INIT_CYC);
    endtask

    // Hand a frame over with a one-cycle valid, then scribble over the inputs.
    task automatic start_frame(input logic [255:0] w);
        int cnt = 0;
        while (bus.lcd_ready !== 1'b1 && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        chk("ready before frame", {31'd0, bus.lcd_ready}, 1);
        set_words(w);
        bus.lcd_valid = 1'b1;
        @(negedge clk);
        bus.lcd_valid = 1'b0;
        set_words({8{32'hFFFF_FFFF}});
    endtask

    task automatic finish_frame(input string name);
        int low = 0;
        while (bus.lcd_ready !== 1'b1 && low < BUDGET) begin
            low++;
            bus.lcd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.lcd_valid = 1'b0;
        chk({name, " ready low cycles"}, low, FRAME_CYC);
    endtask

    initial begin
        int         cnt;
        int         target;
        logic [255:0] rw;

        vecs[0].w   = {32'h706F6E6D, 32'h6C6B6A69, 32'h68676665, 32'h64636261,
                       32'h34333231, 32'h20444C52, 32'h4F57204F, 32'h4C4C4548};
        vecs[0].c0  = 8'h48;
        vecs[0].c31 = 8'h70;
        vecs[1].w   = {32'h1F1E1D1C, 32'h1B1A1918, 32'h17161514, 32'h13121110,
                       32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
        vecs[1].c0  = 8'h00;
        vecs[1].c31 = 8'h1F;
        vecs[2].w   = '0;
        vecs[2].c0  = 8'h00;
        vecs[2].c31 = 8'h00;
        vecs[3].w   = {8{32'hFFFF_FFFF}};
        vecs[3].c0  = 8'hFF;
        vecs[3].c31 = 8'hFF;
        vecs[4].w   = {{7{32'h20202020}}, 32'h20202041};
        vecs[4].c0  = 8'h41;
        vecs[4].c31 = 8'h20;

        rst_n = 1'b0;
        bus.lcd_valid = 1'b0;
        set_words('0);
        clear_queues();
        repeat (3) @(negedge clk);
        chk("reset lcd_ready", {31'd0, bus.lcd_ready}, 0);
        chk("reset lcd_e", {31'd0, lcd_e}, 0);
        chk("reset lcd_rs", {31'd0, lcd_rs}, 0);
        chk("reset lcd_rw", {31'd0, lcd_rw}, 0);
        chk("reset lcd_db", {24'd0, lcd_db}, 0);

        model_init();
        rst_n = 1'b1;
        wait_init("init");
        compare_stream("init");

        for (int i = 0; i < 5; i++) begin
            model_frame(vecs[i].w);
            start_frame(vecs[i].w);
            finish_frame("table frame");
            chk("table first char", {24'd0, cap_byte(1)}, {24'd0, vecs[i].c0});
            chk("table last char", {24'd0, cap_byte(33)}, {24'd0, vecs[i].c31});
            compare_stream("table frame");
        end

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) rw[32 * j +: 32] = $urandom;
            model_frame(rw);
            start_frame(rw);
            finish_frame("random frame");
            compare_stream("random frame");
        end

        // Reset while E is high for the 10th character of line 0.
        start_frame(vecs[0].w);
        target = rise_cnt + 10 * RPB + 1;
        cnt = 0;
        @(negedge clk);
        #1;
        while (!(rise_cnt == target && lcd_e === 1'b1) && cnt < BUDGET) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        chk("reached 10th char pulse", {31'd0, lcd_e}, 1);
        rst_n = 1'b0;
        #1;
        chk("lcd_e drops on reset", {31'd0, lcd_e}, 0);
        chk("ready low on reset", {31'd0, bus.lcd_ready}, 0);
        repeat (3) @(negedge clk);
        clear_queues();
        model_init();
        rst_n = 1'b1;
        wait_init("re-init");
        compare_stream("re-init");

        model_frame(vecs[1].w);
        start_frame(vecs[1].w);
        finish_frame("post-reset frame");
        compare_stream("post-reset frame");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
